// File: rtl/sweep_pkg.sv
// sweep_pkg -- shared definitions for the vector sweep controller.
//   * sweep_state_e  : controller FSM state encoding
//   * VEC_ORDER      : sweep order table, entry i is the vector applied at step i
//   * SETTLE_CYCLES_DEF : default number of hold cycles per vector
//   * popcount8      : bit count helper used by the optional compare logic
package sweep_pkg;

  localparam int VEC_WIDTH         = 3;
  localparam int NUM_VEC           = 8;
  localparam int SETTLE_CYCLES_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } sweep_state_e;

  // Entry [0] is the least significant slice: 000, 001, 010, 100, 011, 110, 101, 111.
  localparam logic [NUM_VEC-1:0][VEC_WIDTH-1:0] VEC_ORDER = {
    3'b111, 3'b101, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001, 3'b000
  };

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/vector_sweep_ctrl_if.sv
// vector_sweep_ctrl_if -- groups the request/status and circuit-under-test
// signals of the sweep controller.
//   start        host -> ctrl   one-cycle sweep request
//   expected     host -> ctrl   golden truth table (bit k = output for input k)
//   dut_out      cut  -> ctrl   output of the circuit under test
//   dut_in       ctrl -> cut    stimulus vector (bit2 = in1, bit1 = in2, bit0 = in3)
//   busy, done   ctrl -> host   sweep status
//   result       ctrl -> host   captured truth table
//   mismatch, mismatch_cnt      ctrl -> host   compare outcome (zero when not built)
//
// Handshake: a start pulse is accepted only on a cycle where busy == 0 and
// done == 0; it is then consumed immediately (busy rises on the same edge).
// Starts seen while busy or done are dropped, never queued. done is a single
// cycle pulse, and result/mismatch/mismatch_cnt are valid from that cycle
// until the next accepted start.
//   modport slave  : the controller
//   modport master : the host / environment driving it
interface vector_sweep_ctrl_if;
  import sweep_pkg::*;

  logic                 start;
  logic [7:0]           expected;
  logic                 dut_out;
  logic [VEC_WIDTH-1:0] dut_in;
  logic                 busy;
  logic                 done;
  logic [7:0]           result;
  logic                 mismatch;
  logic [3:0]           mismatch_cnt;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, result, mismatch, mismatch_cnt
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, result, mismatch, mismatch_cnt
  );

endinterface

// File: rtl/sweep_settle_cnt.sv
// sweep_settle_cnt -- loadable 8-bit down-counter with terminal-count flag.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   dec       : decrement by one, saturating at 0
//   load_val  : value to load
//   count     : current count
//   tc        : terminal count, high while count == 1
module sweep_settle_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  // The hold phase ends on the cycle the counter shows 1, so a load of N
  // gives exactly N hold cycles.
  assign tc = (count == 8'd1);

endmodule

// File: rtl/vector_sweep_ctrl.sv
// vector_sweep_ctrl -- applies all eight 3-bit vectors to a combinational
// circuit in a fixed order, holds each for SETTLE_CYCLES cycles, samples the
// circuit output and assembles the captured truth table.
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset, aborts any sweep
//   bus       : vector_sweep_ctrl_if.slave (start/expected/dut_out in,
//               dut_in/busy/done/result/mismatch/mismatch_cnt out)
//   dbg_state : current FSM state
// Parameters: SETTLE_CYCLES (1..255) hold cycles per vector, VEC_W (fixed 3).
// Build option: define SWEEP_CHECK_EN to build the result-vs-expected
// compare (mismatch, mismatch_cnt); otherwise both outputs are tied to 0.
module vector_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int VEC_W         = 3
) (
  input  logic                clk,
  input  logic                rst,
  vector_sweep_ctrl_if.slave  bus,
  output sweep_state_e        dbg_state
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

  sweep_state_e     state;
  sweep_state_e     state_nxt;
  logic [2:0]       idx;
  logic [7:0]       result_q;
  logic [7:0]       result_cap;
  logic [VEC_W-1:0] cur_vec;
  logic [7:0]       settle_count;
  logic             settle_tc;
  logic             cnt_load;
  logic             cnt_dec;
  logic             accept;
  logic             capture;
  logic             idx_inc;
  logic             last_capture;

  sweep_settle_cnt u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (SETTLE_LD),
    .count    (settle_count),
    .tc       (settle_tc)
  );

  assign cur_vec = VEC_ORDER[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    idx_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (settle_tc) begin
          state_nxt = ST_CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        if (idx != 3'd7) begin
          idx_inc   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign last_capture = capture && (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 3'd0;
    end else if (accept) begin
      idx <= 3'd0;
    end else if (idx_inc) begin
      idx <= idx + 3'd1;
    end
  end

  // Truth table including the bit being captured this cycle; the compare
  // logic needs the complete table on the edge that enters FINISH.
  always_comb begin
    result_cap          = result_q;
    result_cap[cur_vec] = bus.dut_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 8'd0;
    end else if (accept) begin
      result_q <= 8'd0;
    end else if (capture) begin
      result_q <= result_cap;
    end
  end

`ifdef SWEEP_CHECK_EN
  logic       mismatch_q;
  logic [3:0] mismatch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q     <= 1'b0;
      mismatch_cnt_q <= 4'd0;
    end else if (accept) begin
      mismatch_q     <= 1'b0;
      mismatch_cnt_q <= 4'd0;
    end else if (last_capture) begin
      mismatch_q     <= |(result_cap ^ bus.expected);
      mismatch_cnt_q <= popcount8(result_cap ^ bus.expected);
    end
  end

  assign bus.mismatch     = mismatch_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
`else
  assign bus.mismatch     = 1'b0;
  assign bus.mismatch_cnt = 4'd0;
`endif

  // The vector is only driven while a sweep is active; IDLE and FINISH show 000.
  assign bus.dut_in = ((state == ST_HOLD) || (state == ST_CAPTURE)) ? cur_vec : '0;
  assign bus.busy   = (state == ST_HOLD) || (state == ST_CAPTURE);
  assign bus.done   = (state == ST_FINISH);
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// tb_vector_sweep_ctrl -- bench for vector_sweep_ctrl. Two instances run side
// by side: u_a with SETTLE_CYCLES = 7 and u_b with SETTLE_CYCLES = 1. Each
// circuit under test is a truth-table lookup (majority = E8, XOR = 96, or a
// random table), and the expected per-cycle behaviour is derived from the
// sweep rules with plain arithmetic on the cycle count since start.
module tb_vector_sweep_ctrl;
  import sweep_pkg::*;

  localparam int SA   = 7;
  localparam int SB   = 1;
  localparam int NO_K = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_sweep_ctrl_if a_if ();
  vector_sweep_ctrl_if b_if ();
  sweep_state_e a_dbg;
  sweep_state_e b_dbg;

  logic [7:0] tt_a = 8'd0;
  logic [7:0] tt_b = 8'd0;

  // Circuits under test: pure truth-table lookups.
  assign a_if.dut_out = tt_a[a_if.dut_in];
  assign b_if.dut_out = tt_b[b_if.dut_in];

  vector_sweep_ctrl #(.SETTLE_CYCLES(SA), .VEC_W(3)) u_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (a_if),
    .dbg_state (a_dbg)
  );

  vector_sweep_ctrl #(.SETTLE_CYCLES(SB), .VEC_W(3)) u_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (b_if),
    .dbg_state (b_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [2:0] order [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd5, 3'd7};
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected compare outcome for a captured table tt against golden table g.
  function automatic logic exp_mm(input logic [7:0] tt, input logic [7:0] g);
`ifdef SWEEP_CHECK_EN
    return (tt != g);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_mmc(input logic [7:0] tt, input logic [7:0] g);
`ifdef SWEEP_CHECK_EN
    return 4'($countones(tt ^ g));
`else
    return 4'd0;
`endif
  endfunction

  // Cycle k counts negedges after the start edge (k = 0 is the first).
  task automatic model_check(input string tag, input int s, input int k, input int abort_k,
                             input logic busy, input logic done, input logic [2:0] din);
    int len;
    logic eb, ed;
    logic [2:0] ev;
    len = 8 * (s + 1);
    if (k >= abort_k || k > len) begin
      eb = 1'b0; ed = 1'b0; ev = 3'd0;
    end else if (k == len) begin
      eb = 1'b0; ed = 1'b1; ev = 3'd0;
    end else begin
      eb = 1'b1; ed = 1'b0; ev = order[k / (s + 1)];
    end
    check({tag, "_busy"},   32'(busy), 32'(eb));
    check({tag, "_done"},   32'(done), 32'(ed));
    check({tag, "_dut_in"}, 32'(din),  32'(ev));
  endtask

  // ---------------- driver ----------------
  task automatic run_sweep(input logic [7:0] tta, input logic [7:0] ttb,
                           input logic [7:0] ga, input logic [7:0] gb,
                           input int inj_k, input int abort_k);
    int done_a, done_b, len_a, len_b, last;
    len_a = 8 * (SA + 1);
    len_b = 8 * (SB + 1);
    last  = len_a + 4;
    tt_a = tta; tt_b = ttb;
    a_if.expected = ga; b_if.expected = gb;
    if (abort_k > len_a) exp_q.push_back(tta);
    done_a = 0; done_b = 0;
    @(negedge clk);
    a_if.start = 1'b1; b_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0; b_if.start = 1'b0;
    check("a_mm_clear", 32'(a_if.mismatch), 32'd0);
    check("b_mmc_clear", 32'(b_if.mismatch_cnt), 32'd0);
    for (int k = 0; k < last; k++) begin
      model_check("a", SA, k, abort_k, a_if.busy, a_if.done, a_if.dut_in);
      model_check("b", SB, k, abort_k, b_if.busy, b_if.done, b_if.dut_in);
      if (a_if.done) begin
        done_a++;
        if (exp_q.size() > 0) check("a_result", 32'(a_if.result), 32'(exp_q.pop_front()));
        check("a_mismatch", 32'(a_if.mismatch), 32'(exp_mm(tta, ga)));
        check("a_mm_cnt", 32'(a_if.mismatch_cnt), 32'(exp_mmc(tta, ga)));
      end
      if (b_if.done) begin
        done_b++;
        check("b_result", 32'(b_if.result), 32'(ttb));
        check("b_mismatch", 32'(b_if.mismatch), 32'(exp_mm(ttb, gb)));
        check("b_mm_cnt", 32'(b_if.mismatch_cnt), 32'(exp_mmc(ttb, gb)));
      end
      if (k == abort_k) begin
        check("a_abort_result", 32'(a_if.result), 32'd0);
        check("a_abort_state", 32'(a_dbg), 32'(ST_IDLE));
      end
      a_if.start = (k == inj_k - 1);
      rst        = (k == abort_k - 1);
      @(negedge clk);
    end
    rst = 1'b0;
    check("a_done_count", 32'(done_a), (abort_k <= len_a) ? 32'd0 : 32'd1);
    check("b_done_count", 32'(done_b), (abort_k <= len_b) ? 32'd0 : 32'd1);
    // Results and compare outcome hold until the next accepted start.
    check("a_result_hold", 32'(a_if.result), (abort_k < last) ? 32'd0 : 32'(tta));
    check("b_result_hold", 32'(b_if.result), (abort_k < last) ? 32'd0 : 32'(ttb));
    check("a_mm_hold", 32'(a_if.mismatch), (abort_k < last) ? 32'd0 : 32'(exp_mm(tta, ga)));
    check("b_mmc_hold", 32'(b_if.mismatch_cnt), (abort_k < last) ? 32'd0 : 32'(exp_mmc(ttb, gb)));
    check("a_exp_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    a_if.start = 1'b0; b_if.start = 1'b0;
    a_if.expected = 8'd0; b_if.expected = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_done", 32'(a_if.done), 32'd0);
    check("rst_dut_in", 32'(a_if.dut_in), 32'd0);
    check("rst_result", 32'(a_if.result), 32'd0);
    check("rst_mismatch", 32'(a_if.mismatch), 32'd0);
    check("rst_mm_cnt", 32'(a_if.mismatch_cnt), 32'd0);
    check("rst_state", 32'(a_dbg), 32'(ST_IDLE));

    // Majority on the slow instance, XOR on the fast one.
    run_sweep(8'hE8, 8'h96, 8'hE8, 8'h96, NO_K, NO_K);
    // Single-bit golden errors.
    run_sweep(8'hE8, 8'h96, 8'hE9, 8'h97, NO_K, NO_K);
    // Second start in the middle of the slow sweep is dropped.
    run_sweep(8'hE8, 8'h96, 8'hE8, 8'h96, 20, NO_K);
    // Reset at cycle 30 aborts the slow sweep.
    run_sweep(8'hE8, 8'h96, 8'hE8, 8'h96, NO_K, 30);

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    rst = 1'b1; a_if.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_if.start = 1'b0;
    check("rst_start_busy", 32'(a_if.busy), 32'd0);
    check("rst_start_state", 32'(a_dbg), 32'(ST_IDLE));
    @(negedge clk);
    check("rst_start_stay", 32'(a_if.busy), 32'd0);

    // Random truth tables and golden tables.
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb, ga, gb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ga = (i % 2 == 0) ? ra : 8'($urandom_range(0, 255));
      gb = (i % 3 == 0) ? rb : 8'($urandom_range(0, 255));
      run_sweep(ra, rb, ga, gb, (i == 4) ? 40 : NO_K, NO_K);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_sweep_ctrl.md
VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 7: clock cycles each input vector is held before the circuit output is sampled; legal range 1..255.
REQ-002 Parameter VEC_W, default 3: width of the stimulus vector driven to the 3-input combinational circuit under test; fixed at 3 for this revision.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin an 8-vector sweep.
REQ-007 dut_out  input  1  output of the circuit under test (out1).
REQ-008 expected  input  8  golden truth table; bit k is the expected dut_out for input value k.
REQ-009 dut_in  output  3  stimulus to the circuit under test; bit 2 = in1, bit 1 = in2, bit 0 = in3.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 result  output  8  captured truth table; bit k is dut_out sampled while dut_in == k.
REQ-013 mismatch  output  1  high if result != expected after the sweep (SWEEP_CHECK_EN only).
REQ-014 mismatch_cnt  output  4  number of mismatching bits, 0..8 (SWEEP_CHECK_EN only).

Function
REQ-015 FSM states: IDLE, HOLD, CAPTURE, FINISH.
REQ-016 Vector order (index 0..7): 000, 001, 010, 100, 011, 110, 101, 111.
REQ-017 In IDLE, start == 1 at edge N: load index 0, enter HOLD, and drive dut_in = 000 from edge N; busy = 1 from edge N.
REQ-018 In HOLD: hold dut_in for SETTLE_CYCLES cycles counted from the edge the vector was applied; the settle counter is 8 bits and counts down to 1.
REQ-019 In CAPTURE (one cycle): write dut_out into result[dut_in]; if index < 7, increment the index, apply the next vector and return to HOLD; otherwise enter FINISH.
REQ-020 Each vector occupies exactly SETTLE_CYCLES+1 cycles (SETTLE_CYCLES in HOLD plus 1 in CAPTURE).
REQ-021 In FINISH (one cycle): done = 1, busy = 0, dut_in = 000; on the next edge go to IDLE.
REQ-022 Done latency: done is asserted exactly 8*(SETTLE_CYCLES+1) cycles after the start edge.
REQ-023 start is ignored while busy = 1 or done = 1; no queuing.
REQ-024 result is cleared to 0 on an accepted start and holds its final value after the sweep until the next accepted start.
REQ-025 In IDLE, dut_in = 000.

Reset
REQ-026 On rst: state = IDLE, dut_in = 000, busy = 0, done = 0, result = 0, mismatch = 0, mismatch_cnt = 0, index = 0, settle counter = 0.
REQ-027 rst asserted mid-sweep aborts the sweep: no done pulse, and partial results are discarded.
REQ-028 rst takes priority over a simultaneous start.

Configuration
REQ-029 Macro SWEEP_CHECK_EN defined: in FINISH, mismatch = |(result ^ expected) and mismatch_cnt = popcount(result ^ expected); both are registered and valid from the done cycle until the next accepted start, and are cleared on an accepted start.
REQ-030 Macro SWEEP_CHECK_EN undefined: mismatch and mismatch_cnt are tied to 0, expected is unused, and no compare logic is built.

Structure
REQ-031 A shared package sweep_pkg holds the FSM state enum, the 8-entry vector-order constant table, and the default SETTLE_CYCLES value.
REQ-032 One sub-module, sweep_settle_cnt (loadable 8-bit down-counter with a terminal-count flag), implements the settle counter.

Verification
REQ-033 DUT model = 3-input majority, SETTLE_CYCLES = 7, pulse start -> done exactly 64 cycles later; result = 8'hE8; dut_in visits 000, 001, 010, 100, 011, 110, 101, 111, each held for 8 cycles.
REQ-034 SWEEP_CHECK_EN defined, majority DUT, expected = 8'hE8 -> mismatch = 0, mismatch_cnt = 0; with expected = 8'hE9 -> mismatch = 1, mismatch_cnt = 1.
REQ-035 Pulse start again at cycle 20 of an active sweep -> ignored; done still occurs at cycle 64, and exactly one done pulse is produced.
REQ-036 Assert rst at cycle 30 of a sweep -> next cycle: busy = 0, dut_in = 000, result = 0, and no done pulse occurs.
REQ-037 SETTLE_CYCLES = 1, DUT = 3-input XOR -> done 16 cycles after start; result = 8'h96.
REQ-038 Assert rst and start in the same cycle -> state remains IDLE and busy = 0.
